gbuff_out_drain: RTL

Read-side controller for the output global buffer. After the systolic array has written result lines, it walks lines 0..num_lines-1 through the buffer's single index/wr_en port. It captures each line and serialises it as BEAT_W-bit beats on a valid/ready stream toward the host/DMA side. An optional mode writes zeros back to each line after it is captured (clear-on-read).

---
 rtl/gbuff_out_drain.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gbuff_out_drain.sv
// Output global-buffer drain: walks lines, serialises each as beat stream.
// Define GBUFF_DRAIN_CLEAR_EN to zero each line in the cycle it is captured.
module gbuff_out_drain #(
  parameter int LINE_W = 1184,
  parameter int IDX_W  = 5,
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W:0]    num_lines,
  output logic              busy,
  output logic              done,
  output logic              gb_wr_en,
  output logic [IDX_W-1:0]  gb_index,
  output logic [LINE_W-1:0] gb_data_in,
  input  logic [LINE_W-1:0] gb_data_out,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BEAT_W-1:0] m_data,
  output logic              m_last
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_SEND,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W:0]                r_num;
  logic [IDX_W-1:0]              r_line_cnt;
  logic [BCW-1:0]                r_beat_cnt;
  logic [BEATS-1:0][BEAT_W-1:0]  r_line_reg;

  logic w_last_beat;
  logic w_last_line;
  logic w_xfer;

  assign w_last_beat = (r_beat_cnt == BCW'(BEATS - 1));
  assign w_last_line = ({1'b0, r_line_cnt} == (r_num - 1'b1));
  assign w_xfer      = (r_state == S_SEND) && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (num_lines == '0) ? S_DONE : S_RD;
        end
      end
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_SEND;
      S_SEND: begin
        if (w_xfer && w_last_beat) begin
          w_next = w_last_line ? S_DONE : S_RD;
        end
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num      <= '0;
      r_line_cnt <= '0;
      r_beat_cnt <= '0;
      r_line_reg <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num      <= num_lines;
            r_line_cnt <= '0;
          end
        end
        S_CAP: begin
          r_line_reg <= gb_data_out;
          r_beat_cnt <= '0;
        end
        S_SEND: begin
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            // terminal check first, so line_cnt never wraps
            if (w_last_beat && !w_last_line) begin
              r_line_cnt <= r_line_cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    m_valid    = (r_state == S_SEND);
    m_last     = (r_state == S_SEND) && w_last_beat;
    m_data     = '0;
    gb_index   = '0;
    gb_data_in = '0;
    gb_wr_en   = 1'b0;
    if (r_state == S_SEND) begin
      m_data = r_line_reg[r_beat_cnt];
    end
    if ((r_state == S_RD) || (r_state == S_CAP) ||
        (r_state == S_SEND)) begin
      gb_index = r_line_cnt;
    end
`ifdef GBUFF_DRAIN_CLEAR_EN
    gb_wr_en = (r_state == S_CAP);
`else
    gb_wr_en = 1'b0;
`endif
  end

endmodule
